// File: rtl/tooth_period_meter_pkg.sv
// Shared definitions for the crank tooth period meter.
// Holds the measurement FSM state encoding and the parameter defaults used
// by the interface, the synchronizer sub-module and the top level.
package tooth_period_meter_pkg;

  // IDLE: no reference edge yet (or the last period overran); RUN: timing a tooth.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } meter_state_e;

  localparam int DEF_PERIOD_WIDTH = 16;
  localparam int DEF_PRESCALE_DIV = 8;
  localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/tooth_period_meter_if.sv
// Measurement bus of the tooth period meter.
// Ports (signals):
//   trig_in      - asynchronous crank tooth trigger (rising edge = tooth)
//   min_period   - noise-rejection threshold in ticks, quasi-static
//   period       - last accepted tooth period in ticks
//   period_valid - one-clk pulse when period updates
//   stalled      - no valid measurement reference (engine stopped)
// Modports: master = the meter, slave = trigger source / period consumer.
interface tooth_period_meter_if #(
  parameter int PERIOD_WIDTH = tooth_period_meter_pkg::DEF_PERIOD_WIDTH
);

  logic                    trig_in;
  logic [PERIOD_WIDTH-1:0] min_period;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    period_valid;
  logic                    stalled;

  modport master (
    input  trig_in,
    input  min_period,
    output period,
    output period_valid,
    output stalled
  );

  modport slave (
    output trig_in,
    output min_period,
    input  period,
    input  period_valid,
    input  stalled
  );

endinterface

// File: rtl/tooth_period_meter_sync.sv
// trig_sync_edge: brings the asynchronous tooth trigger into the clk domain
// and flags its rising edges.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset
//   trig_in - asynchronous trigger
//   rise    - one-clk pulse per synchronized rising edge (built from flops only)
module trig_sync_edge
  import tooth_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic trig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   last_r;

  // Synchronizer chain plus the registered copy used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      last_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], trig_in};
      last_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // A level held high yields a single pulse because last_r follows it.
  assign rise = sync_r[SYNC_STAGES-1] & ~last_r;

endmodule

// File: rtl/tooth_period_meter.sv
// tooth_period_meter: measures the time between crank tooth edges in
// prescaled ticks, rejects edges arriving too early and reports a stall when
// the count overruns.
// Ports:
//   clk   - clock, all logic on its rising edge
//   reset - synchronous active-high reset
//   bus   - measurement bus (trig_in, min_period in; period, period_valid,
//           stalled out; all outputs registered)
module tooth_period_meter
  import tooth_period_meter_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int PRESCALE_DIV = DEF_PRESCALE_DIV,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   reset,
  tooth_period_meter_if.master   bus
);

  localparam int PRE_W = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0]        PRE_ZERO = '0;
  localparam logic [PRE_W-1:0]        PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0]        PRE_LAST = PRE_W'(PRESCALE_DIV - 1);
  localparam logic [PERIOD_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX  = '1;

  meter_state_e            state_r, state_nx;
  logic [PRE_W-1:0]        presc_r, presc_nx;
  logic [PERIOD_WIDTH-1:0] cnt_r, cnt_nx;
  logic [PERIOD_WIDTH-1:0] period_r, period_nx;
  logic                    valid_r, valid_nx;
  logic                    stalled_r, stalled_nx;
  logic                    rise_s;
  logic                    tick_s;

  trig_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .trig_in (bus.trig_in),
    .rise    (rise_s)
  );

  assign tick_s = (presc_r == PRE_LAST);

  // State and measurement registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      presc_r   <= PRE_ZERO;
      cnt_r     <= CNT_ZERO;
      period_r  <= CNT_ZERO;
      valid_r   <= 1'b0;
      stalled_r <= 1'b1;
    end else begin
      state_r   <= state_nx;
      presc_r   <= presc_nx;
      cnt_r     <= cnt_nx;
      period_r  <= period_nx;
      valid_r   <= valid_nx;
      stalled_r <= stalled_nx;
    end
  end

  // Next-state and next-output logic of the measurement FSM.
  always_comb begin
    state_nx   = state_r;
    presc_nx   = presc_r;
    cnt_nx     = cnt_r;
    period_nx  = period_r;
    valid_nx   = 1'b0;
    stalled_nx = stalled_r;
    // The edge cycle itself is prescaler cycle 0 of the new period, so the
    // register restarts at 1; a tooth N*PRESCALE_DIV clk later then reads N.
    case (state_r)
      IDLE: begin
        presc_nx = PRE_ZERO;
        if (rise_s) begin
          state_nx   = RUN;
          presc_nx   = PRE_ONE;
          cnt_nx     = CNT_ZERO;
          stalled_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        presc_nx = tick_s ? PRE_ZERO : presc_r + PRE_ONE;
        if (rise_s && (cnt_r >= bus.min_period)) begin
          // Edge beats a coincident tick: the pre-tick count is reported.
          period_nx = cnt_r;
          valid_nx  = 1'b1;
          cnt_nx    = CNT_ZERO;
          presc_nx  = PRE_ONE;
        end else if (cnt_r == CNT_MAX) begin
          state_nx   = IDLE;
          stalled_nx = 1'b1;
          cnt_nx     = CNT_ZERO;
          presc_nx   = PRE_ZERO;
        end else if (tick_s) begin
          cnt_nx = cnt_r + CNT_ONE;
        end else begin
          cnt_nx = cnt_r;
        end
      end
      default: begin
        state_nx   = IDLE;
        presc_nx   = PRE_ZERO;
        cnt_nx     = CNT_ZERO;
        stalled_nx = 1'b1;
      end
    endcase
  end

  assign bus.period       = period_r;
  assign bus.period_valid = valid_r;
  assign bus.stalled      = stalled_r;

endmodule

// File: doc/tooth_period_meter.md
TOOTH_PERIOD_METER -- requirements
Module: tooth_period_meter

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 16, width of the period value in prescaled ticks.
REQ-002 SHALL have parameter PRESCALE_DIV, default 8, number of clk cycles per tick (valid range 2 or more).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on trig_in (valid range 2 or more).
REQ-004 SHALL have port clk, input, width 1, the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port reset, input, width 1, synchronous, active-high.
REQ-006 SHALL have port trig_in, input, width 1, asynchronous crank tooth trigger; a rising edge marks a tooth.
REQ-007 SHALL have port min_period, input, width PERIOD_WIDTH, noise-rejection threshold in ticks, quasi-static.
REQ-008 SHALL have port period, output, width PERIOD_WIDTH, last accepted tooth period in ticks; feeds the d input of the rpm shift register chain.
REQ-009 SHALL have port period_valid, output, width 1, one-clk pulse when period updates; drives the chain en.
REQ-010 SHALL have port stalled, output, width 1, high when there is no valid measurement reference (engine stopped).

Function
REQ-011 SHALL pass trig_in through a SYNC_STAGES flop synchronizer, then rising-edge detect against a registered copy of the synchronized signal.
REQ-012 SHALL run a prescaler from 0 to PRESCALE_DIV-1, producing a tick in the cycle it equals PRESCALE_DIV-1, then wrap to 0.
REQ-013 SHALL implement FSM states IDLE and RUN; reset enters IDLE.
REQ-014 In IDLE, a detected edge SHALL go to RUN, clear the prescaler and tick counter, clear stalled, and SHALL NOT pulse period_valid.
REQ-015 In RUN, each tick SHALL increment the tick counter, saturating at 2^PERIOD_WIDTH-1.
REQ-016 In RUN, a detected edge with tick counter >= min_period SHALL load period with the counter value, pulse period_valid for exactly one cycle, and clear the counter and prescaler.
REQ-017 In RUN, a detected edge with tick counter < min_period SHALL be ignored; counting continues and period and period_valid are unchanged.
REQ-018 An edge and a tick in the same cycle SHALL resolve with the edge winning; the counter value before that tick is used, and the tick is discarded.
REQ-019 When the counter reaches 2^PERIOD_WIDTH-1 in RUN, the block SHALL go to IDLE and set stalled, without pulsing period_valid; period holds its last value.
REQ-020 Latency SHALL be SYNC_STAGES+1 clk edges from the first edge sampling trig_in high to period_valid high (3 by default).
REQ-021 A trig_in held high SHALL produce exactly one edge.

Reset
REQ-022 Reset SHALL force: state=IDLE, period=0, period_valid=0, stalled=1, prescaler=0, counter=0, synchronizer and edge flops=0.
REQ-023 Reset asserted mid-measurement SHALL discard the partial count; the first edge after reset only arms the meter (per REQ-014).

Structure
REQ-024 The FSM state encoding and parameter defaults SHALL live in a shared package/include.
REQ-025 The synchronizer plus edge detector SHALL be one sub-module, trig_sync_edge (parameter SYNC_STAGES; outputs rise pulse).
REQ-026 The total RTL SHALL be a single clock domain with no combinational path from trig_in to any output.

Verification (PRESCALE_DIV=8, PERIOD_WIDTH=16, min_period=4)
REQ-027 Release reset, then edges every 800 clk -> first edge gives no valid and stalled 1->0; second and later edges give period=100 with a 1-cycle valid, 3 clk after the edge.
REQ-028 Glitch edge 16 clk after an accepted edge -> ignored; next edge 800 clk after the accepted one gives period=100.
REQ-029 No edge for 65535*8 clk after an accepted edge -> stalled=1 with no valid; next edge gives no valid; following edge 80 clk later gives period=10.
REQ-030 Reset pulse 400 clk into a period -> all outputs at reset values; next edge gives no valid; edge 800 clk later gives period=100.
REQ-031 min_period=0 with edges every 8 clk -> period=1 on each edge; trig_in held high for 2000 clk -> exactly one edge processed.
